// File: rtl/mb_bus_master.sv
// Single-word bus initiator for the MicroBlaze-style slave bus; polls the status hold flags before data-window accesses.
// Optional timeouts on polls and acks are compiled in with `define MB_MASTER_TIMEOUT_EN.
module mb_bus_master #(
  parameter logic [31:0] STATUS_ADDR = 32'h80F00004,
  parameter int          POLL_LIMIT  = 1024,
  parameter int          ACK_LIMIT   = 16
) (
  input  logic        MB_CLK,
  input  logic        MB_RESET,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_RNW,
  input  logic [31:0] CMD_ADDR,
  input  logic [31:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic [31:0] MB_ADRESS,
  output logic        MB_CS,
  output logic        MB_RNW,
  output logic [31:0] MB_DATA_IN,
  input  logic [31:0] MB_DATA_OUT,
  input  logic        MB_RD_ACK
);

  typedef enum logic [2:0] {IDLE, POLL_ISSUE, POLL_WAIT, ACCESS, RD_WAIT, RESP} state_t;
  typedef enum logic [1:0] {PC_NONE, PC_WR, PC_RD} poll_t;

  typedef struct packed {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    poll_t       pclass;
  } cmd_t;

  state_t state, state_nxt;
  cmd_t   cmd_in, cmd_q, cmd_cur;
  logic   hold_bit;
  logic   poll_exh, ack_tmo;

  always_comb begin
    cmd_in.rnw    = CMD_RNW;
    cmd_in.addr   = CMD_ADDR;
    cmd_in.wdata  = CMD_WDATA;
    cmd_in.pclass = PC_NONE;
    if (!CMD_RNW && CMD_ADDR >= 32'h8000_0000 && CMD_ADDR < 32'h8080_0000)
      cmd_in.pclass = PC_WR;
    else if (CMD_RNW && CMD_ADDR >= 32'h8080_0000 && CMD_ADDR < 32'h80F0_0000)
      cmd_in.pclass = PC_RD;
  end

  // A NONE-class command issues its access on the accept edge, before cmd_q is loaded.
  assign cmd_cur   = (state == IDLE) ? cmd_in : cmd_q;
  assign hold_bit  = (cmd_q.pclass == PC_WR) ? MB_DATA_OUT[1] : MB_DATA_OUT[0];
  assign CMD_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (CMD_VALID) state_nxt = (cmd_in.pclass == PC_NONE) ? ACCESS : POLL_ISSUE;
      POLL_ISSUE: state_nxt = POLL_WAIT;
      POLL_WAIT: begin
        if (MB_RD_ACK) begin
          if (!hold_bit)    state_nxt = ACCESS;
          else if (poll_exh) state_nxt = RESP;
          else              state_nxt = POLL_ISSUE;
        end else if (ack_tmo) begin
          state_nxt = RESP;
        end
      end
      ACCESS:     state_nxt = cmd_q.rnw ? RD_WAIT : RESP;
      RD_WAIT:    if (MB_RD_ACK || ack_tmo) state_nxt = RESP;
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Bus and response outputs are registered from the next state so they line up with it.
  always_ff @(posedge MB_CLK or posedge MB_RESET) begin
    if (MB_RESET) begin
      state      <= IDLE;
      cmd_q      <= '0;
      MB_CS      <= 1'b0;
      MB_RNW     <= 1'b1;
      MB_ADRESS  <= '0;
      MB_DATA_IN <= '0;
      RSP_VALID  <= 1'b0;
      RSP_RDATA  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && CMD_VALID) cmd_q <= cmd_in;
      MB_CS <= (state_nxt == POLL_ISSUE) || (state_nxt == ACCESS);
      if (state_nxt == POLL_ISSUE) begin
        MB_RNW    <= 1'b1;
        MB_ADRESS <= STATUS_ADDR;
      end else if (state_nxt == ACCESS) begin
        MB_RNW     <= cmd_cur.rnw;
        MB_ADRESS  <= cmd_cur.addr;
        MB_DATA_IN <= cmd_cur.wdata;
      end
      RSP_VALID <= (state_nxt == RESP);
      if (state_nxt == RESP)
        RSP_RDATA <= (state == RD_WAIT && MB_RD_ACK) ? MB_DATA_OUT : 32'h0;
    end
  end

`ifdef MB_MASTER_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int AW = $clog2(ACK_LIMIT + 1);

  logic [PW-1:0] poll_cnt;
  logic [AW-1:0] wait_cnt;
  logic          err_nxt, rsp_err_q;

  assign poll_exh = (poll_cnt >= PW'(POLL_LIMIT));
  assign ack_tmo  = (wait_cnt >= AW'(ACK_LIMIT - 1));
  assign err_nxt  = (state == POLL_WAIT && ((MB_RD_ACK && hold_bit && poll_exh) || (!MB_RD_ACK && ack_tmo)))
                 || (state == RD_WAIT && !MB_RD_ACK && ack_tmo);
  assign RSP_ERR  = rsp_err_q;

  always_ff @(posedge MB_CLK or posedge MB_RESET) begin
    if (MB_RESET) begin
      poll_cnt  <= '0;
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_nxt == POLL_ISSUE)
        poll_cnt <= (state == IDLE) ? PW'(1) : poll_cnt + 1'b1;
      else if (state == IDLE)
        poll_cnt <= '0;
      // Counts silent cycles within one wait; any state change restarts it.
      if ((state == POLL_WAIT || state == RD_WAIT) && state_nxt == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (state_nxt == RESP) rsp_err_q <= err_nxt;
    end
  end
`else
  assign poll_exh = 1'b0;
  assign ack_tmo  = 1'b0;
  assign RSP_ERR  = 1'b0;
`endif

endmodule
